// File: rtl/mw_input_conditioner_if.sv
// rtl/mw_input_conditioner_if.sv - raw operator inputs and conditioned outputs of the microwave front end
interface mw_input_conditioner_if;
    logic [9:0] keypad_raw;
    logic       startn_raw;
    logic       stopn_raw;
    logic       clearn_raw;
    logic       door_raw;

    logic [9:0] keypad_onehot;
    logic [3:0] key_code;
    logic       key_valid;
    logic       multi_key_err;
    logic       start_pulse;
    logic       stop_pulse;
    logic       clear_pulse;
    logic       door_closed;

    modport master (
        output keypad_raw, startn_raw, stopn_raw, clearn_raw, door_raw,
        input  keypad_onehot, key_code, key_valid, multi_key_err,
        input  start_pulse, stop_pulse, clear_pulse, door_closed
    );

    modport slave (
        input  keypad_raw, startn_raw, stopn_raw, clearn_raw, door_raw,
        output keypad_onehot, key_code, key_valid, multi_key_err,
        output start_pulse, stop_pulse, clear_pulse, door_closed
    );
endinterface

// File: rtl/mw_input_conditioner.sv
// rtl/mw_input_conditioner.sv - sync, debounce and pulse generation for keypad, buttons and door
module mw_input_conditioner #(
    parameter int DB_CYCLES = 3,
    parameter int CNT_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mw_input_conditioner_if.slave bus
);
    localparam int NIN = 14;
    // Idle level per input: keys released, active-low buttons high, door open.
    // Button sync flops start high too so reset never fakes a press.
    localparam logic [NIN-1:0]   REST     = {1'b0, 3'b111, 10'b0};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {IDLE, HELD} key_state_t;

    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   sync1;
    logic [NIN-1:0]   sync2;
    logic [NIN-1:0]   stable;
    logic [CNT_W-1:0] cnt [NIN];
    logic [2:0]       btn_d;
    logic [2:0]       btn_pulse;

    key_state_t state, state_nxt;
    logic [9:0] kd;
    logic       kd_one;
    logic [3:0] kd_idx;
    logic       key_valid_q, key_valid_nxt;
    logic       err_q, err_nxt;
    logic [9:0] onehot_q, onehot_nxt;
    logic [3:0] code_q, code_nxt;

    assign raw = {bus.door_raw, bus.clearn_raw, bus.stopn_raw, bus.startn_raw, bus.keypad_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= REST;
            sync2  <= REST;
            stable <= REST;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Buttons are active-low: a stable 1->0 transition is a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d     <= 3'b111;
            btn_pulse <= 3'b000;
        end else begin
            btn_d     <= stable[12:10];
            btn_pulse <= btn_d & ~stable[12:10];
        end
    end

    assign kd     = stable[9:0];
    assign kd_one = (kd != 10'd0) && ((kd & (kd - 10'd1)) == 10'd0);

    always_comb begin
        kd_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (kd[i]) kd_idx = 4'(i);
        end
    end

    always_comb begin
        state_nxt     = state;
        key_valid_nxt = 1'b0;
        err_nxt       = 1'b0;
        onehot_nxt    = 10'd0;
        code_nxt      = code_q;
        case (state)
            IDLE: begin
                if (kd_one) begin
                    key_valid_nxt = 1'b1;
                    onehot_nxt    = kd;
                    code_nxt      = kd_idx;
                    state_nxt     = HELD;
                end else if (kd != 10'd0) begin
                    err_nxt   = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (kd == 10'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            onehot_q    <= 10'd0;
            code_q      <= 4'd0;
        end else begin
            state       <= state_nxt;
            key_valid_q <= key_valid_nxt;
            err_q       <= err_nxt;
            onehot_q    <= onehot_nxt;
            code_q      <= code_nxt;
        end
    end

    assign bus.keypad_onehot = onehot_q;
    assign bus.key_code      = code_q;
    assign bus.key_valid     = key_valid_q;
    assign bus.multi_key_err = err_q;
    assign bus.start_pulse   = btn_pulse[0];
    assign bus.stop_pulse    = btn_pulse[1];
    assign bus.clear_pulse   = btn_pulse[2];
    assign bus.door_closed   = stable[13];
endmodule

// File: tb/tb_mw_input_conditioner.sv
// tb/tb_mw_input_conditioner.sv - scoreboard bench for mw_input_conditioner
module tb_mw_input_conditioner;
    localparam int K_KEY = 0, K_MKE = 1, K_START = 2, K_STOP = 3, K_CLEAR = 4;

    typedef struct {
        int         kind;
        int         code;
        logic [9:0] onehot;
        int         tmin;
        int         tmax;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    mw_input_conditioner_if bus();

    mw_input_conditioner #(.DB_CYCLES(3), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int code, input logic [9:0] onehot,
                             input int tmin, input int tmax);
        exp_t e;
        e.kind = kind; e.code = code; e.onehot = onehot; e.tmin = tmin; e.tmax = tmax;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int code, input logic [9:0] onehot);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("unexpected_pulse_kind", kind, -1);
            return;
        end
        e = sb.pop_front();
        check_val("kind", kind, e.kind);
        if (e.kind == K_KEY) begin
            check_val("key_code", code, e.code);
            check_val("keypad_onehot", int'(onehot), int'(e.onehot));
        end
        if (e.tmin == e.tmax) check_val("cycle", cyc, e.tmin);
        else                  check_val("in_window", int'(cyc >= e.tmin && cyc <= e.tmax), 1);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && cyc > sb[0].tmax) begin
            check_val("timeout", cyc, sb[0].tmax);
            void'(sb.pop_front());
        end
        if (bus.key_valid)     observe(K_KEY, int'(bus.key_code), bus.keypad_onehot);
        if (!bus.key_valid && bus.keypad_onehot !== 10'd0)
            check_val("onehot_idle", int'(bus.keypad_onehot), 0);
        if (bus.multi_key_err) observe(K_MKE, 0, 10'd0);
        if (bus.start_pulse)   observe(K_START, 0, 10'd0);
        if (bus.stop_pulse)    observe(K_STOP, 0, 10'd0);
        if (bus.clear_pulse)   observe(K_CLEAR, 0, 10'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string pfx);
        check_val({pfx, "_key_valid"}, int'(bus.key_valid), 0);
        check_val({pfx, "_multi_key_err"}, int'(bus.multi_key_err), 0);
        check_val({pfx, "_onehot"}, int'(bus.keypad_onehot), 0);
        check_val({pfx, "_key_code"}, int'(bus.key_code), 0);
        check_val({pfx, "_start"}, int'(bus.start_pulse), 0);
        check_val({pfx, "_stop"}, int'(bus.stop_pulse), 0);
        check_val({pfx, "_clear"}, int'(bus.clear_pulse), 0);
        check_val({pfx, "_door"}, int'(bus.door_closed), 0);
    endtask

    initial begin
        bus.keypad_raw = 10'd0;
        bus.startn_raw = 1'b1;
        bus.stopn_raw  = 1'b1;
        bus.clearn_raw = 1'b1;
        bus.door_raw   = 1'b0;
        rst = 1'b1;
        step(3);
        check_quiet("reset");
        rst = 1'b0;
        step(6);

        // single key 7, exact latency, nothing on release
        bus.keypad_raw = 10'b0010000000;
        expect_ev(K_KEY, 7, 10'b0010000000, cyc + 6, cyc + 6);
        step(10);
        bus.keypad_raw = 10'd0;
        step(12);

        // bouncing key 1 then stable high
        for (int i = 0; i < 8; i++) begin
            bus.keypad_raw = (i % 2 == 0) ? 10'b0000000010 : 10'd0;
            step(1);
        end
        bus.keypad_raw = 10'b0000000010;
        expect_ev(K_KEY, 1, 10'b0000000010, cyc + 6, cyc + 6);
        step(10);
        bus.keypad_raw = 10'd0;
        step(12);

        // two keys together, then a single key
        bus.keypad_raw = 10'b0000000110;
        expect_ev(K_MKE, 0, 10'd0, cyc + 6, cyc + 6);
        step(10);
        bus.keypad_raw = 10'd0;
        step(12);
        bus.keypad_raw = 10'b0000001000;
        expect_ev(K_KEY, 3, 10'b0000001000, cyc + 6, cyc + 6);
        step(10);
        bus.keypad_raw = 10'd0;
        step(12);

        // short start glitch ignored, long press gives one pulse
        bus.startn_raw = 1'b0;
        step(2);
        bus.startn_raw = 1'b1;
        step(12);
        bus.startn_raw = 1'b0;
        expect_ev(K_START, 0, 10'd0, cyc + 6, cyc + 6);
        step(10);
        bus.startn_raw = 1'b1;
        step(12);

        // door: level after 5 edges, short opening ignored
        bus.door_raw = 1'b1;
        step(4);
        check_val("door_before", int'(bus.door_closed), 0);
        step(1);
        check_val("door_after", int'(bus.door_closed), 1);
        step(5);
        bus.door_raw = 1'b0;
        step(2);
        bus.door_raw = 1'b1;
        step(4);
        check_val("door_glitch_a", int'(bus.door_closed), 1);
        step(4);
        check_val("door_glitch_b", int'(bus.door_closed), 1);

        // stop and clear on the same edge
        bus.stopn_raw  = 1'b0;
        bus.clearn_raw = 1'b0;
        expect_ev(K_STOP, 0, 10'd0, cyc + 6, cyc + 6);
        expect_ev(K_CLEAR, 0, 10'd0, cyc + 6, cyc + 6);
        step(10);
        bus.stopn_raw  = 1'b1;
        bus.clearn_raw = 1'b1;
        step(12);

        // key 4 held across a one-cycle reset
        bus.keypad_raw = 10'b0000010000;
        expect_ev(K_KEY, 4, 10'b0000010000, cyc + 6, cyc + 6);
        step(10);
        rst = 1'b1;
        step(1);
        check_quiet("midreset");
        rst = 1'b0;
        expect_ev(K_KEY, 4, 10'b0000010000, cyc + 6, cyc + 8);
        step(12);
        bus.keypad_raw = 10'd0;
        step(15);

        check_val("pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
